spi_rom_arbiter: RTL and testbench

SPI_ROM_ARBITER -- requirements
Module: spi_rom_arbiter

---
 rtl/spi_rom_arbiter.sv | 132 +++++++++++++
 tb/tb_spi_rom_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rom_arbiter.sv
// Two-requester arbiter that serves SPI flash reads (03h + 24-bit address),
// returning bytes on rd_data/rd_valid with a starvation guard for requester 1.
module spi_rom_arbiter #(
  parameter int GAP_CYCLES   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [23:0] addr0,
  input  logic [23:0] addr1,
  input  logic [4:0]  len0,
  input  logic [4:0]  len1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        rd_last,
  output logic        rd_src,
  output logic        busy,
  output logic        spi_cs,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam logic [3:0] SL      = 4'(STARVE_LIMIT);
  localparam logic [3:0] GAP_END = 4'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, GAP} state_t;
  state_t state, state_n;

  logic [8:0]  bit_idx, nxt_idx, end_idx;
  logic        phase;          // 1: next edge raises sclk, 0: next edge shifts a bit
  logic [30:0] sh;
  logic [7:0]  dsh;
  logic [3:0]  gap_cnt, starve_cnt;
  logic        accept, pick1, shifting;
  logic [4:0]  len_sel;
  logic [5:0]  n_bytes;

  always_comb begin
    pick1    = req1 && (!req0 || starve_cnt == SL);
    accept   = (state == IDLE) && (req0 || req1);
    nxt_idx  = bit_idx + 9'd1;
    shifting = (state inside {CMD, ADDR, DATA}) && !phase;
    len_sel  = pick1 ? len1 : len0;
    n_bytes  = (len_sel == 5'd0) ? 6'd32 : {1'b0, len_sel};
    state_n  = state;
    case (state)
      IDLE: if (accept) state_n = CMD;
      CMD, ADDR, DATA:
        if (shifting) begin
          if (nxt_idx == end_idx)     state_n = GAP;
          else if (nxt_idx >= 9'd32)  state_n = DATA;
          else if (nxt_idx >= 9'd8)   state_n = ADDR;
        end
      GAP:  if (gap_cnt == GAP_END) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt0 <= 1'b0; gnt1 <= 1'b0; rd_data <= '0; rd_valid <= 1'b0; rd_last <= 1'b0;
      rd_src <= 1'b0; spi_cs <= 1'b0; spi_sclk <= 1'b0; spi_mosi <= 1'b0;
      bit_idx <= '0; end_idx <= '0; phase <= 1'b0; sh <= '0; dsh <= '0;
      gap_cnt <= '0; starve_cnt <= '0;
    end else begin
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      case (state)
        IDLE: begin
          // Starvation count only tracks req0 wins that happen while req1 waits.
          if (!req1 || (accept && pick1)) starve_cnt <= '0;
          else if (accept && starve_cnt != SL) starve_cnt <= starve_cnt + 4'd1;
          if (accept) begin
            gnt0     <= !pick1;
            gnt1     <= pick1;
            rd_src   <= pick1;
            sh       <= {7'b0000011, pick1 ? addr1 : addr0};
            end_idx  <= 9'd32 + {n_bytes, 3'b000};
            bit_idx  <= '0;
            phase    <= 1'b1;
            spi_cs   <= 1'b1;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;  // MSB of 03h
          end
        end
        CMD, ADDR, DATA: begin
          if (phase) begin
            spi_sclk <= 1'b1;
            phase    <= 1'b0;
            if (state == DATA) begin
              dsh <= {dsh[6:0], spi_miso};
              if (bit_idx[2:0] == 3'd7) begin
                rd_data  <= {dsh[6:0], spi_miso};
                rd_valid <= 1'b1;
                rd_last  <= (nxt_idx == end_idx);
              end
            end
          end else begin
            spi_sclk <= 1'b0;
            if (nxt_idx == end_idx) begin
              spi_cs   <= 1'b0;
              spi_mosi <= 1'b0;
              gap_cnt  <= '0;
            end else begin
              spi_mosi <= (nxt_idx < 9'd32) ? sh[30] : 1'b0;
              sh       <= {sh[29:0], 1'b0};
              bit_idx  <= nxt_idx;
              phase    <= 1'b1;
            end
          end
        end
        GAP:     gap_cnt <= gap_cnt + 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_rom_arbiter.sv
// Directed bench for spi_rom_arbiter with a behavioural SPI flash on spi_miso.
module tb_spi_rom_arbiter;
  logic clk = 1'b0, reset = 1'b1, req0 = 1'b0, req1 = 1'b0, spi_miso = 1'b0;
  logic [23:0] addr0 = '0, addr1 = '0;
  logic [4:0]  len0 = '0, len1 = '0;
  logic gnt0, gnt1, rd_valid, rd_last, rd_src, busy, spi_cs, spi_sclk, spi_mosi;
  logic [7:0] rd_data;

  spi_rom_arbiter #(.GAP_CYCLES(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .len0(len0), .len1(len1), .gnt0(gnt0), .gnt1(gnt1), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_last(rd_last), .rd_src(rd_src), .busy(busy),
    .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Flash model: byte j of every read is exp_base + j; presents the next bit after each sclk rise.
  logic [7:0]  exp_base = 8'hA5;
  logic [31:0] mosi_word;
  int rcnt = 0, mosi_bad = 0;
  always @(posedge spi_cs) begin rcnt = 0; mosi_word = '0; mosi_bad = 0; end
  always @(posedge spi_sclk) begin
    logic [7:0] b;
    int k;
    if (rcnt < 32) mosi_word = {mosi_word[30:0], spi_mosi};
    else if (spi_mosi !== 1'b0) mosi_bad++;
    rcnt++;
    if (rcnt >= 32) begin
      k = rcnt - 32;
      b = exp_base + 8'(k >> 3);
      spi_miso = b[7 - (k & 7)];
    end
  end

  // Observation counters relative to the acceptance edge (t=0).
  int t, g0_n, g1_n, g0_t, g1_t, v_n, vi, v_first, v_last, l_n, l_t, bad_data;
  int cs_fall, busy_fall, both, gap_lo, busy_n;
  logic [7:0] last_data;
  logic prev_cs, prev_busy;
  int gseq[$], gtimes[$];

  task automatic step(); @(posedge clk); #1; endtask

  task automatic clear_stats();
    t = 0; g0_n = 0; g1_n = 0; g0_t = -1; g1_t = -1; v_n = 0; vi = 0; v_first = -1;
    v_last = -1; l_n = 0; l_t = -1; bad_data = 0; cs_fall = -1; busy_fall = -1;
    both = 0; gap_lo = 0; busy_n = 0; last_data = '0; prev_cs = spi_cs; prev_busy = busy;
    gseq.delete(); gtimes.delete();
  endtask

  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      if (gnt0) begin g0_n++; g0_t = t; vi = 0; gseq.push_back(0); gtimes.push_back(t); end
      if (gnt1) begin g1_n++; g1_t = t; vi = 0; gseq.push_back(1); gtimes.push_back(t); end
      if (gnt0 && gnt1) both++;
      if (rd_valid) begin
        if (v_n == 0) v_first = t;
        if (rd_data !== exp_base + 8'(vi)) bad_data++;
        v_n++; vi++; v_last = t; last_data = rd_data;
        if (rd_last) begin l_n++; l_t = t; end
      end
      if (!spi_cs && prev_cs && cs_fall < 0) cs_fall = t;
      if (!busy && prev_busy && busy_fall < 0) busy_fall = t;
      if (!spi_cs && busy) gap_lo++;
      if (busy) busy_n++;
      prev_cs = spi_cs; prev_busy = busy;
      step(); t++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req0 = 1'b1;
    step(); step();
    if ({gnt0, gnt1, rd_valid, rd_last, rd_src, busy, spi_cs, spi_sclk, spi_mosi, rd_data} !== 17'd0) begin
      failures++; $display("FAIL reset_outputs got=%h want=0",
        {gnt0, gnt1, rd_valid, rd_last, rd_src, busy, spi_cs, spi_sclk, spi_mosi, rd_data});
    end
    checks++;
    req0 = 1'b0; step();
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_precedence busy=%b want=0", busy); end
    checks++;
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    exp_base = 8'hA5; addr0 = 24'h000123; len0 = 5'd1; req0 = 1'b1;
    step();
    if ({gnt0, gnt1, spi_cs, busy, rd_src} !== 5'b10110) begin
      failures++; $display("FAIL single_accept got=%b want=10110", {gnt0, gnt1, spi_cs, busy, rd_src});
    end
    checks++;
    req0 = 1'b0; addr0 = 24'hFFFFFF; len0 = 5'd7;  // post-grant changes must not matter
    clear_stats(); watch(95);
    if (mosi_word !== 32'h03000123) begin failures++; $display("FAIL single_mosi got=%h want=03000123", mosi_word); end
    checks++;
    if (mosi_bad != 0) begin failures++; $display("FAIL single_mosi_data got=%0d want=0", mosi_bad); end
    checks++;
    if (v_n != 1 || v_first != 79 || l_t != 79) begin
      failures++; $display("FAIL single_valid n=%0d t=%0d last_t=%0d want 1/79/79", v_n, v_first, l_t);
    end
    checks++;
    if (last_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%h want=a5", last_data); end
    checks++;
    if (cs_fall != 80) begin failures++; $display("FAIL single_cs_fall got=%0d want=80", cs_fall); end
    checks++;
    if (busy_fall != 82) begin failures++; $display("FAIL single_busy_fall got=%0d want=82", busy_fall); end
    checks++;
    if (g0_n != 1 || g1_n != 0) begin failures++; $display("FAIL single_gnt g0=%0d g1=%0d want 1/0", g0_n, g1_n); end
    checks++;
  endtask

  task automatic test_len32();
    do_reset();
    exp_base = 8'h10; addr0 = 24'hABCDEF; len0 = 5'd0; req0 = 1'b1;
    step(); req0 = 1'b0;
    clear_stats(); watch(600);
    if (v_n != 32 || v_first != 79 || v_last != 575) begin
      failures++; $display("FAIL len32_valid n=%0d first=%0d last=%0d want 32/79/575", v_n, v_first, v_last);
    end
    checks++;
    if (l_n != 1 || l_t != 575) begin failures++; $display("FAIL len32_last n=%0d t=%0d want 1/575", l_n, l_t); end
    checks++;
    if (bad_data != 0 || last_data !== 8'h2F) begin
      failures++; $display("FAIL len32_data bad=%0d last=%h want 0/2f", bad_data, last_data);
    end
    checks++;
    if (cs_fall != 576) begin failures++; $display("FAIL len32_cs_fall got=%0d want=576", cs_fall); end
    checks++;
    if (mosi_word !== 32'h03ABCDEF) begin failures++; $display("FAIL len32_mosi got=%h want=03abcdef", mosi_word); end
    checks++;
  endtask

  task automatic test_starve();
    int exp_seq[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    do_reset();
    exp_base = 8'h3C; len0 = 5'd1; len1 = 5'd1; req0 = 1'b1; req1 = 1'b1;
    step();
    clear_stats(); watch(835);
    req0 = 1'b0; req1 = 1'b0;
    if (gseq.size() < 10) begin failures++; $display("FAIL starve_count got=%0d want>=10", gseq.size()); end
    else for (int i = 0; i < 10; i++) begin
      if (gseq[i] != exp_seq[i]) begin failures++; $display("FAIL starve_seq[%0d] got=%0d want=%0d", i, gseq[i], exp_seq[i]); end
      checks++;
    end
    checks++;
    if (gtimes.size() < 2 || gtimes[1] != 83) begin failures++; $display("FAIL starve_spacing got=%0d want=83",
      gtimes.size() < 2 ? -1 : gtimes[1]); end
    checks++;
    if (both != 0 || bad_data != 0) begin failures++; $display("FAIL starve_excl both=%0d bad=%0d want 0/0", both, bad_data); end
    checks++;
    watch(100);
  endtask

  task automatic test_abort();
    do_reset();
    exp_base = 8'h77; addr1 = 24'h000456; len1 = 5'd4; req1 = 1'b1;
    step();
    if (gnt1 !== 1'b1 || rd_src !== 1'b1) begin failures++; $display("FAIL abort_gnt gnt1=%b src=%b want 1/1", gnt1, rd_src); end
    checks++;
    req1 = 1'b0;
    clear_stats(); watch(40);
    reset = 1'b1; step(); reset = 1'b0;
    if ({spi_cs, busy, rd_valid} !== 3'b000) begin failures++; $display("FAIL abort_cs got=%b want=000", {spi_cs, busy, rd_valid}); end
    checks++;
    clear_stats(); watch(100);
    if (v_n != 0 || busy_n != 0) begin failures++; $display("FAIL abort_quiet valid=%0d busy=%0d want 0/0", v_n, busy_n); end
    checks++;
    len1 = 5'd1; req1 = 1'b1;
    step();
    if (gnt1 !== 1'b1) begin failures++; $display("FAIL abort_regrant gnt1=%b want=1", gnt1); end
    checks++;
    req1 = 1'b0;
    clear_stats(); watch(90);
    if (v_n != 1 || last_data !== 8'h77) begin failures++; $display("FAIL abort_after n=%0d data=%h want 1/77", v_n, last_data); end
    checks++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    exp_base = 8'hC0; addr1 = 24'h123456; len1 = 5'd2; req1 = 1'b1;
    step();
    clear_stats(); watch(100);
    req1 = 1'b0;
    if (g1_n != 2 || g1_t != 99) begin failures++; $display("FAIL b2b_second_gnt n=%0d t=%0d want 2/99", g1_n, g1_t); end
    checks++;
    if (gap_lo != 2) begin failures++; $display("FAIL b2b_gap got=%0d want=2", gap_lo); end
    checks++;
    if (cs_fall != 96 || v_n != 2) begin failures++; $display("FAIL b2b_first cs=%0d n=%0d want 96/2", cs_fall, v_n); end
    checks++;
    watch(110);
  endtask

  task automatic test_ignore();
    do_reset();
    exp_base = 8'h5E; addr1 = 24'h00BEEF; len1 = 5'd2; req1 = 1'b1;
    step(); req1 = 1'b0;
    clear_stats(); watch(70);
    req0 = 1'b1; watch(20);
    req0 = 1'b0; watch(30);
    if (g0_n != 0 || g1_n != 1) begin failures++; $display("FAIL ignore_gnt g0=%0d g1=%0d want 0/1", g0_n, g1_n); end
    checks++;
    if (v_n != 2 || bad_data != 0 || l_t != 95) begin
      failures++; $display("FAIL ignore_data n=%0d bad=%0d last_t=%0d want 2/0/95", v_n, bad_data, l_t);
    end
    checks++;
    if (cs_fall != 96 || mosi_word !== 32'h0300BEEF) begin
      failures++; $display("FAIL ignore_frame cs=%0d mosi=%h want 96/0300beef", cs_fall, mosi_word);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_len32();
    test_starve();
    test_abort();
    test_back_to_back();
    test_ignore();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
